// File: rtl/des_core_param.sv
// Iterative DES engine (encrypt/decrypt) applying ROUNDS_PER_CYCLE Feistel rounds per clock.
// Data and keys use DES bit numbering: DES bit 1 is the MSB of each vector.
module des_core_param #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] desIn,
  input  logic [63:0] keyIn,
  output logic        busy,
  output logic        ready,
  output logic [63:0] desOut
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("des_core_param: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] RCNT_STEP = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] RCNT_LAST = 4'(16 - ROUNDS_PER_CYCLE);

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // Rotation applied to C,D before each round (index = round - 1).
  localparam int LSH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int RSH_T [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] expand_e(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [5:0]  b;
    logic [31:0] s;
    x = expand_e(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      // Row is the outer bit pair, column the inner four bits.
      b = 6'(x >> (42 - 6 * i));
      s = {s[27:0], 4'(SBOX_T[3'(i)][{b[5], b[0], b[4:1]}])};
    end
    return perm_p(s);
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input int amt, input logic right);
    if (right) return (x >> amt) | (x << (28 - amt));
    return (x << amt) | (x >> (28 - amt));
  endfunction

  // One clock's worth of chained rounds; returns {L, R, C, D}.
  function automatic logic [119:0] rounds_fn(input logic [31:0] l_in, input logic [31:0] r_in,
                                             input logic [27:0] c_in, input logic [27:0] d_in,
                                             input logic dec, input logic [3:0] rc);
    logic [31:0] l, r, t;
    logic [27:0] c, d;
    int          idx, amt;
    l = l_in; r = r_in; c = c_in; d = d_in;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      idx = int'(rc) + j;
      amt = dec ? RSH_T[4'(idx)] : LSH_T[4'(idx)];
      c = rot28(c, amt, dec);
      d = rot28(d, amt, dec);
      t = l ^ f_fn(r, perm_pc2({c, d}));
      l = r;
      r = t;
    end
    return {l, r, c, d};
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [31:0] l_q, l_d, r_q, r_d, l_n, r_n;
  logic [27:0] c_q, c_d, d_q, d_d, c_n, d_n;
  logic        mode_q, mode_d;
  logic [63:0] dout_q, dout_d;

  assign {l_n, r_n, c_n, d_n} = rounds_fn(l_q, r_q, c_q, d_q, mode_q, rcnt_q);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          {l_d, r_d} = perm_ip(desIn);
          {c_d, d_d} = perm_pc1(keyIn);
          mode_d     = decrypt;
          rcnt_d     = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        l_d    = l_n;
        r_d    = r_n;
        c_d    = c_n;
        d_d    = d_n;
        rcnt_d = rcnt_q + RCNT_STEP;
        if (rcnt_q == RCNT_LAST) begin
          dout_d  = perm_fp({r_n, l_n});
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign ready  = (state_q == S_DONE);
  assign desOut = dout_q;

endmodule

// File: tb/tb_des_core_param.sv
// Bench for des_core_param: one lane per legal ROUNDS_PER_CYCLE, each with its own
// driver and a monitor that pops the expected-result queue whenever ready rises.
module tb_des_core_param;

  logic clk;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Known-answer vectors: {decrypt, input, key, expected}.
  bit          tv_dec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [63:0] tv_in  [4] = '{64'h0123456789ABCDEF, 64'h85E813540F0AB405,
                              64'h0000000000000000, 64'h8CA64DE9C1B123A7};
  logic [63:0] tv_key [4] = '{64'h133457799BBCDFF1, 64'h133457799BBCDFF1,
                              64'h0000000000000000, 64'h0101010101010101};
  logic [63:0] tv_exp [4] = '{64'h85E813540F0AB405, 64'h0123456789ABCDEF,
                              64'h8CA64DE9C1B123A7, 64'h0000000000000000};

  task automatic chk(input string name, input int rpc, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (R=%0d): got %h, expected %h", name, rpc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_lane
    localparam int RPC = 1 << g;
    localparam int N   = 16 / RPC;

    logic        rst_n, start, decrypt, busy, ready;
    logic [63:0] des_in, key_in, des_out;
    logic [63:0] exp_q [$];
    int          st_q [$];
    int          busy_cnt;
    logic        ready_prev;
    bit          done = 1'b0;

    des_core_param #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .decrypt(decrypt),
      .desIn  (des_in),
      .keyIn  (key_in),
      .busy   (busy),
      .ready  (ready),
      .desOut (des_out)
    );

    // Caller is at a negedge; the following posedge captures the block.
    task automatic kick(input bit dec, input logic [63:0] din, input logic [63:0] key,
                        input logic [63:0] expv);
      start   = 1'b1;
      decrypt = dec;
      des_in  = din;
      key_in  = key;
      exp_q.push_back(expv);
      st_q.push_back(cyc);
      @(negedge clk);
      start   = 1'b0;
      decrypt = 1'($urandom_range(0, 1));
      des_in  = {$urandom, $urandom};
      key_in  = {$urandom, $urandom};
    endtask

    task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 64) begin
        @(negedge clk);
        t++;
      end
      chk("drain_timeout", RPC, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_block(input int v);
      @(negedge clk);
      kick(tv_dec[v], tv_in[v], tv_key[v], tv_exp[v]);
      drain();
    endtask

    task automatic ignore_mid_run();
      @(negedge clk);
      kick(tv_dec[0], tv_in[0], tv_key[0], tv_exp[0]);
      repeat ((N + 1) / 2 - 1) @(negedge clk);
      start   = 1'b1;
      decrypt = 1'b1;
      des_in  = 64'hFEDCBA9876543210;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      chk("hold_ready", RPC, 64'(ready), 64'd1);
      chk("hold_desOut", RPC, des_out, tv_exp[0]);
    endtask

    task automatic back_to_back();
      @(negedge clk);
      for (int b = 0; b < 3; b++) begin
        start   = 1'b1;
        decrypt = tv_dec[b];
        des_in  = tv_in[b];
        key_in  = tv_key[b];
        exp_q.push_back(tv_exp[b]);
        st_q.push_back(cyc);
        if (b < 2) repeat (N + 1) @(negedge clk);
      end
      @(negedge clk);
      start = 1'b0;
      drain();
    endtask

    task automatic reset_abort();
      @(negedge clk);
      kick(tv_dec[0], tv_in[0], tv_key[0], tv_exp[0]);
      repeat ((N + 1) / 2 - 1) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", RPC, 64'(busy), 64'd0);
      chk("abort_ready", RPC, 64'(ready), 64'd0);
      chk("abort_desOut", RPC, des_out, 64'd0);
      repeat (3) @(negedge clk);
      chk("abort_idle_busy", RPC, 64'(busy), 64'd0);
      rst_n = 1'b1;
      run_block(0);
    endtask

    initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      decrypt = 1'b0;
      des_in  = '0;
      key_in  = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", RPC, 64'(busy), 64'd0);
      chk("reset_ready", RPC, 64'(ready), 64'd0);
      chk("reset_desOut", RPC, des_out, 64'd0);
      rst_n = 1'b1;
      for (int v = 0; v < 4; v++) run_block(v);
      ignore_mid_run();
      back_to_back();
      reset_abort();
      done = 1'b1;
    end

    // Monitor: one scoreboard pop per rising edge of ready.
    initial begin
      logic [63:0] exp_v;
      int          st_v;
      busy_cnt   = 0;
      ready_prev = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          st_q.delete();
          busy_cnt   = 0;
          ready_prev = 1'b0;
        end else begin
          if (busy) busy_cnt++;
          if (ready && !ready_prev) begin
            chk("result_expected", RPC, 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              exp_v = exp_q.pop_front();
              st_v  = st_q.pop_front();
              chk("desOut", RPC, des_out, exp_v);
              chk("latency", RPC, 64'(cyc - st_v - 1), 64'(N));
              chk("busy_cycles", RPC, 64'(busy_cnt), 64'(N));
            end
            busy_cnt = 0;
          end
          ready_prev = ready;
        end
      end
    end
  end

  wire all_done = g_lane[0].done & g_lane[1].done & g_lane[2].done &
                  g_lane[3].done & g_lane[4].done;

  initial begin
    int t = 0;
    while (!all_done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("all_lanes_finished", 0, 64'(all_done), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
